// File: rtl/option_rom_read_sequencer.sv
// option_rom_read_sequencer: turns BAR-5 read requests into ROM DWORD reads buffered as completion payload beats
module option_rom_read_sequencer #(
  parameter int ROM_SIZE   = 65536,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [9:0]  req_len,
  input  logic [7:0]  req_tag,
  output logic        rom_rd_en,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_rd_data,
  output logic        cpl_valid,
  input  logic        cpl_ready,
  output logic [31:0] cpl_data,
  output logic [7:0]  cpl_tag,
  output logic        cpl_first,
  output logic        cpl_last,
  output logic [11:0] cpl_byte_count,
  output logic        cpl_oor,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  tag;
    logic        first;
    logic        last;
    logic [11:0] byte_count;
    logic        oor;
  } entry_t;
  state_t        state;
  logic [29:0]   addr;
  logic [10:0]   remaining;
  logic [7:0]    tag;
  logic          first;
  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, issue, in_range;
  entry_t        head;
  assign in_range       = {addr, 2'b00} < 32'(ROM_SIZE);
  assign full           = count == (AW+1)'(FIFO_DEPTH);
  assign cpl_valid      = count != '0;
  assign pop            = cpl_valid && cpl_ready;
  assign issue          = state == ISSUE && (!full || pop);
  assign rom_rd_en      = issue && in_range;
  assign rom_addr       = {addr, 2'b00};
  assign req_ready      = state == IDLE;
  assign busy           = state != IDLE;
  assign head           = cpl_valid ? mem[rd_ptr] : '0;
  assign cpl_data       = head.data;
  assign cpl_tag        = head.tag;
  assign cpl_first      = head.first;
  assign cpl_last       = head.last;
  assign cpl_byte_count = head.byte_count;
  assign cpl_oor        = head.oor;
  // Request FSM: latch the request, issue one beat per free FIFO slot, then wait for the drain
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      tag       <= '0;
      first     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr      <= req_addr[31:2];
          remaining <= {req_len == 10'd0, req_len};
          tag       <= req_tag;
          first     <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: if (issue) begin
          addr      <= addr + 30'd1;
          remaining <= remaining - 11'd1;
          first     <= 1'b0;
          state     <= remaining == 11'd1 ? DRAIN : ISSUE;
        end
        DRAIN: state <= (count == '0 || (pop && count == (AW+1)'(1))) ? IDLE : DRAIN;
        default: state <= IDLE;
      endcase
    end
  end
  // FIFO pointers and occupancy; reset flushes every buffered beat
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(issue);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(issue) - (AW+1)'(pop);
    end
  end
  // FIFO storage; out-of-range beats carry zero data and the oor flag
  always_ff @(posedge clk) begin
    if (issue) mem[wr_ptr] <= {in_range ? rom_rd_data : 32'd0, tag, first, remaining == 11'd1, remaining[9:0], 2'b00, !in_range};
  end
endmodule
